pwm_fader: RTL and testbench

//   Multi-channel PWM LED dimmer; successor to the single-channel fixed 4-bit PWM.
//   CH channels share one prescaled W-bit period counter; each channel has a target duty

---
 rtl/pwm_fader_pkg.sv | 18 +
 rtl/pwm_fader_channel.sv | 63 ++++++
 rtl/pwm_fader.sv | 80 ++++++++
 tb/tb_pwm_fader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_fader_pkg.sv
// Shared types and helpers for the multi-channel PWM fader.
// Channel-index width and per-channel stagger offset live here.
package pwm_fader_pkg;

  typedef enum logic {ModeJump, ModeFade} mode_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Phase offset of channel idx when turn-on edges are spread over the period.
  function automatic int unsigned stagger_offset(input int unsigned idx,
                                                 input int unsigned ch,
                                                 input int unsigned w);
    return idx * ((32'd1 << w) / ch);
  endfunction

endpackage

// File: rtl/pwm_fader_channel.sv
// One PWM channel: target/active duty, jump or ramp update at period edges,
// comparator and registered pwm/busy outputs.
module pwm_fader_channel
  import pwm_fader_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         boundary,
  input  logic         step,
  input  logic [W-1:0] cmp,
  input  logic         wr,
  input  logic [W-1:0] wr_duty,
  input  logic         wr_fade,
  output logic         pwm,
  output logic         busy
);

  logic [W-1:0] target_q;
  logic [W-1:0] active_q, active_d;
  mode_e        mode_q;
  logic         pwm_q, busy_q;

  // All decisions use pre-edge target/mode, so a coinciding write acts next time.
  always_comb begin
    active_d = active_q;
    case (mode_q)
      ModeJump: begin
        if (boundary) active_d = target_q;
      end
      ModeFade: begin
        if (step) begin
          if (active_q < target_q)      active_d = active_q + W'(1);
          else if (active_q > target_q) active_d = active_q - W'(1);
        end
      end
      default: active_d = active_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      target_q <= '0;
      active_q <= '0;
      mode_q   <= ModeJump;
      pwm_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (wr) begin
        target_q <= wr_duty;
        mode_q   <= mode_e'(wr_fade);
      end
      active_q <= active_d;
      pwm_q    <= (cmp < active_q);
      busy_q   <= (active_q != target_q);
    end
  end

  assign pwm  = pwm_q;
  assign busy = busy_q;

endmodule

// File: rtl/pwm_fader.sv
// Multi-channel PWM LED dimmer with shared prescaled period counter and per-channel fade.
// Define PWM_FADER_STAGGER_EN to spread channel turn-on edges across the period.
module pwm_fader
  import pwm_fader_pkg::*;
#(
  parameter int unsigned CH       = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned FADE_DIV = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [idx_width(CH)-1:0] wr_ch,
  input  logic [W-1:0]             wr_duty,
  input  logic                     wr_fade,
  output logic [CH-1:0]            pwm_out,
  output logic [CH-1:0]            busy,
  output logic                     period_start
);

  localparam int unsigned CW = idx_width(CH);
  localparam int unsigned PW = idx_width(PRESCALE);
  localparam int unsigned FW = idx_width(FADE_DIV);

  logic [PW-1:0] presc_q;
  logic [W-1:0]  cnt_q;
  logic [FW-1:0] fade_q;
  logic          period_start_q;
  logic          tick, boundary, step, wr_valid;

  assign tick     = (presc_q == PW'(PRESCALE - 1));
  assign boundary = tick & (cnt_q == '1);
  assign step     = boundary & (fade_q == FW'(FADE_DIV - 1));
  assign wr_valid = wr_en & (32'(wr_ch) < CH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      fade_q         <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= tick ? '0 : presc_q + PW'(1);
      if (tick) cnt_q <= cnt_q + W'(1);
      if (boundary) fade_q <= step ? '0 : fade_q + FW'(1);
      period_start_q <= boundary;
    end
  end

  assign period_start = period_start_q;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0] cmp;
    logic         wr_sel;

`ifdef PWM_FADER_STAGGER_EN
    assign cmp = cnt_q + W'(stagger_offset(i, CH, W));
`else
    assign cmp = cnt_q;
`endif
    assign wr_sel = wr_valid & (wr_ch == CW'(i));

    pwm_fader_channel #(
      .W(W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .boundary (boundary),
      .step     (step),
      .cmp      (cmp),
      .wr       (wr_sel),
      .wr_duty  (wr_duty),
      .wr_fade  (wr_fade),
      .pwm      (pwm_out[i]),
      .busy     (busy[i])
    );
  end

endmodule

// File: tb/tb_pwm_fader.sv
// Directed self-checking bench for pwm_fader (CH=3, W=4, PRESCALE=1, FADE_DIV=2).
module tb_pwm_fader;

  localparam int unsigned CH = 3;
  localparam int unsigned W  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_ch = '0;
  logic [W-1:0]  wr_duty = '0;
  logic          wr_fade = 1'b0;
  logic [CH-1:0] pwm_out;
  logic [CH-1:0] busy;
  logic          period_start;

  int tests = 0;
  int fails = 0;
  int nbnd  = 0;  // period boundaries seen since the last reset

  always #5 clk = ~clk;

  pwm_fader #(
    .CH(3), .W(4), .PRESCALE(1), .FADE_DIV(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_duty      (wr_duty),
    .wr_fade      (wr_fade),
    .pwm_out      (pwm_out),
    .busy         (busy),
    .period_start (period_start)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_ps(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 40);
    if (period_start) nbnd++;
    else begin
      tests++; fails++;
      $display("FAIL %s wait_ps: period_start got 0 required 1 within 40 clks", tag);
    end
  endtask

  task automatic measure(input string tag, output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      c0 += int'(pwm_out[0]);
      c1 += int'(pwm_out[1]);
      c2 += int'(pwm_out[2]);
    end
    if (period_start) nbnd++;
    else begin
      tests++; fails++;
      $display("FAIL %s measure: period_start got 0 required 1 after 16 clks", tag);
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [W-1:0] d, input logic f);
    wr_en = 1'b1; wr_ch = ch; wr_duty = d; wr_fade = f;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (pwm_out !== 3'b000) begin fails++; $display("FAIL reset_pwm: got %b required 000", pwm_out); end
    tests++; if (busy !== 3'b000) begin fails++; $display("FAIL reset_busy: got %b required 000", busy); end
    tests++; if (period_start !== 1'b0) begin fails++; $display("FAIL reset_ps: got %b required 0", period_start); end
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (period_start !== 1'b1 && n < 40);
      tests++;
      if (n != 16) begin fails++; $display("FAIL first_ps_%0d: got %0d clks required 16", k, n); end
      nbnd++;
    end
  endtask

  task automatic test_jump();
    int c0, c1, c2;
    repeat (5) @(negedge clk);
    wr(2'd0, 4'd4, 1'b0);
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL jump_busy_lat: got %b required 0", busy[0]); end
    @(negedge clk);
    tests++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL jump_busy_set: got %b required 1", busy[0]); end
    wait_ps("jump4");
    tests++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL jump_busy_bnd: got %b required 1", busy[0]); end
    measure("jump4", c0, c1, c2);
    tests++; if (c0 != 4) begin fails++; $display("FAIL jump_duty4: got %0d high clks required 4", c0); end
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL jump_busy_clr: got %b required 0", busy[0]); end
    wr(2'd0, 4'd0, 1'b0);
    wait_ps("jump0");
    measure("jump0", c0, c1, c2);
    tests++; if (c0 != 0) begin fails++; $display("FAIL jump_duty0: got %0d high clks required 0", c0); end
    wr(2'd0, 4'd15, 1'b0);
    wait_ps("jump15");
    measure("jump15", c0, c1, c2);
    tests++; if (c0 != 15) begin fails++; $display("FAIL jump_duty15: got %0d high clks required 15", c0); end
  endtask

  task automatic test_ramp();
    int c0, c1, c2;
    int up_d [6] = '{1, 1, 2, 2, 3, 3};
    int up_b [6] = '{1, 1, 1, 1, 0, 0};
    int dn_d [6] = '{3, 2, 2, 1, 1, 0};
    int dn_b [6] = '{1, 1, 1, 1, 1, 0};
    // Steps fall on even boundary counts; start the write just after an odd one.
    if (nbnd % 2 == 0) wait_ps("ramp_align");
    wr(2'd1, 4'd3, 1'b1);
    wait_ps("ramp_up");
    for (int k = 0; k < 6; k++) begin
      measure("ramp_up", c0, c1, c2);
      tests++; if (c1 != up_d[k]) begin fails++; $display("FAIL ramp_up_%0d: got %0d high clks required %0d", k, c1, up_d[k]); end
      tests++; if (busy[1] !== up_b[k][0]) begin fails++; $display("FAIL ramp_up_busy_%0d: got %b required %0d", k, busy[1], up_b[k]); end
    end
    wr(2'd1, 4'd0, 1'b1);
    wait_ps("ramp_dn");
    for (int k = 0; k < 6; k++) begin
      measure("ramp_dn", c0, c1, c2);
      tests++; if (c1 != dn_d[k]) begin fails++; $display("FAIL ramp_dn_%0d: got %0d high clks required %0d", k, c1, dn_d[k]); end
      tests++; if (busy[1] !== dn_b[k][0]) begin fails++; $display("FAIL ramp_dn_busy_%0d: got %b required %0d", k, busy[1], dn_b[k]); end
    end
  endtask

  task automatic test_bad_ch();
    int c0, c1, c2;
    wr(2'd3, 4'd9, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests++; if (busy !== 3'b000) begin fails++; $display("FAIL badch_busy_%0d: got %b required 000", k, busy); end
    end
    wait_ps("badch");
    measure("badch", c0, c1, c2);
    tests++; if (c0 != 15 || c1 != 0 || c2 != 0) begin
      fails++; $display("FAIL badch_duty: got %0d/%0d/%0d required 15/0/0", c0, c1, c2);
    end
    tests++; if (busy !== 3'b000) begin fails++; $display("FAIL badch_busy_end: got %b required 000", busy); end
  endtask

  task automatic test_boundary_write();
    int c0, c1, c2;
    wr(2'd2, 4'd2, 1'b0);
    wait_ps("bw_pre");
    repeat (15) @(negedge clk);
    wr(2'd2, 4'd6, 1'b0);  // this edge is the boundary edge
    tests++;
    if (period_start !== 1'b1) begin fails++; $display("FAIL bw_align: period_start got %b required 1", period_start); end
    else nbnd++;
    measure("bw_old", c0, c1, c2);
    tests++; if (c2 != 2) begin fails++; $display("FAIL bw_old_duty: got %0d high clks required 2", c2); end
    tests++; if (busy[2] !== 1'b1) begin fails++; $display("FAIL bw_busy: got %b required 1", busy[2]); end
    measure("bw_new", c0, c1, c2);
    tests++; if (c2 != 6) begin fails++; $display("FAIL bw_new_duty: got %0d high clks required 6", c2); end
  endtask

  task automatic test_reset_mid_ramp();
    int c0, c1, c2;
    int n;
    wr(2'd1, 4'd10, 1'b1);
    repeat (3) wait_ps("mr_ramp");
    tests++; if (busy[1] !== 1'b1) begin fails++; $display("FAIL mr_busy_pre: got %b required 1", busy[1]); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++; if (pwm_out !== 3'b000) begin fails++; $display("FAIL mr_pwm: got %b required 000", pwm_out); end
    tests++; if (busy !== 3'b000) begin fails++; $display("FAIL mr_busy: got %b required 000", busy); end
    @(negedge clk);
    reset = 1'b1;
    nbnd = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (period_start !== 1'b1 && n < 40);
    tests++;
    if (n != 16) begin fails++; $display("FAIL mr_first_ps: got %0d clks required 16", n); end
    nbnd++;
    measure("mr_after", c0, c1, c2);
    tests++; if (c0 != 0 || c1 != 0 || c2 != 0) begin
      fails++; $display("FAIL mr_duty: got %0d/%0d/%0d required 0/0/0", c0, c1, c2);
    end
    tests++; if (busy !== 3'b000) begin fails++; $display("FAIL mr_busy_after: got %b required 000", busy); end
  endtask

`ifdef PWM_FADER_STAGGER_EN
  task automatic test_stagger();
    int rise [3];
    int cnt [3];
    logic [CH-1:0] prev;
    int c0, c1, c2;
    for (int i = 0; i < 3; i++) wr(2'(i), 4'd8, 1'b0);
    wait_ps("stg");
    measure("stg_settle", c0, c1, c2);
    prev = pwm_out;
    for (int i = 0; i < 3; i++) begin rise[i] = -1; cnt[i] = 0; end
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (pwm_out[i] && !prev[i]) rise[i] = j;
        cnt[i] += int'(pwm_out[i]);
      end
      prev = pwm_out;
    end
    nbnd++;
    // Channel i leads channel 0 by i*5 clks modulo the 16-clk period.
    for (int i = 0; i < 3; i++) begin
      tests++; if (cnt[i] != 8) begin fails++; $display("FAIL stg_duty_%0d: got %0d required 8", i, cnt[i]); end
      tests++;
      if (rise[i] < 0 || ((rise[0] - rise[i] + 16) % 16) != 5 * i) begin
        fails++; $display("FAIL stg_edge_%0d: got rise %0d (ch0 %0d) required lead %0d", i, rise[i], rise[0], 5 * i);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_jump();
    test_ramp();
    test_bad_ch();
    test_boundary_write();
    test_reset_mid_ramp();
`ifdef PWM_FADER_STAGGER_EN
    test_stagger();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
